// File: rtl/dig_arb_pkg.sv
// Shared types for the dig slot arbiter: FSM states and counter widths.
package dig_arb_pkg;

    localparam int ACK_W  = 3;
    localparam int HOLD_W = 8;
    localparam int COOL_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        HOLD,
        COOL
    } arb_state_t;

endpackage

// File: rtl/dig_slot_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after rr_ptr, wrapping.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr_ptr,
    output logic [W-1:0] winner,
    output logic         any
);

    logic [W-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N; i++) begin
            idx = W'((int'(rr_ptr) + i) % N);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/dig_slot_arbiter.sv
// Single dig slot arbiter with ack/hold watchdogs.
// Optional post-release cooldown: define DIG_ARB_COOLDOWN_EN.
module dig_slot_arbiter #(
    parameter int N_AGENTS = 4,
    parameter int ACK_WIN  = 2,
    parameter int MAX_HOLD = 31,
    parameter int COOLDOWN = 3
) (
    input  logic                        clk,
    input  logic                        areset,
    input  logic [N_AGENTS-1:0]         req,
    input  logic [N_AGENTS-1:0]         busy,
    output logic [N_AGENTS-1:0]         grant,
    output logic [$clog2(N_AGENTS)-1:0] owner,
    output logic                        active,
    output logic                        timeout
);

    import dig_arb_pkg::*;

    localparam int OW = $clog2(N_AGENTS);
    localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_WIN - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    if (N_AGENTS < 2 || N_AGENTS > 16 || ACK_WIN < 1 || ACK_WIN > 7 ||
        MAX_HOLD < 1 || MAX_HOLD > 255 || COOLDOWN < 1 || COOLDOWN > 15)
    begin : g_bad_cfg
        $error("dig_slot_arbiter: parameter out of range");
    end

    arb_state_t          state_q, state_d;
    logic [N_AGENTS-1:0] grant_q, grant_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       rr_q, rr_d;
    logic [ACK_W-1:0]    ack_q, ack_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                timeout_q, timeout_d;
    logic                active_q;
    logic                rel;
    logic [OW-1:0]       winner;
    logic                any;

`ifdef DIG_ARB_COOLDOWN_EN
    localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN - 1);
    logic [COOL_W-1:0] cool_q, cool_d;
`endif

    rr_pick #(
        .N (N_AGENTS),
        .W (OW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_q),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        ack_d     = ack_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        rel       = 1'b0;
`ifdef DIG_ARB_COOLDOWN_EN
        cool_d    = cool_q;
`endif
        unique case (state_q)
            IDLE: begin
                ack_d  = '0;
                hold_d = '0;
                if (any) begin
                    owner_d         = winner;
                    rr_d            = winner;
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    state_d         = GRANTED;
                end
            end
            GRANTED: begin
                if (busy[owner_q]) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end else if (ack_q >= ACK_LAST) begin
                    rel       = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    ack_d = ack_q + 1'b1;
                end
            end
            HOLD: begin
                if (!busy[owner_q]) begin
                    rel = 1'b1;
                end else if (hold_q >= HOLD_LAST) begin
                    rel       = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            COOL: begin
`ifdef DIG_ARB_COOLDOWN_EN
                if (cool_q >= COOL_LAST) begin
                    state_d = IDLE;
                end else begin
                    cool_d = cool_q + 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        // every release path funnels through here so grant never skips IDLE
        if (rel) begin
            grant_d = '0;
`ifdef DIG_ARB_COOLDOWN_EN
            state_d = COOL;
            cool_d  = '0;
`else
            state_d = IDLE;
`endif
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            rr_q      <= OW'(N_AGENTS - 1);
            ack_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
            active_q  <= 1'b0;
`ifdef DIG_ARB_COOLDOWN_EN
            cool_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            ack_q     <= ack_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
            active_q  <= |grant_d;
`ifdef DIG_ARB_COOLDOWN_EN
            cool_q    <= cool_d;
`endif
        end
    end

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign active  = active_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_dig_slot_arbiter.sv
// Directed self-checking bench for dig_slot_arbiter.
module tb_dig_slot_arbiter;

    logic       clk = 1'b0;
    logic       areset;
    logic [3:0] req;
    logic [3:0] busy;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       active;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    int order [5] = '{0, 1, 2, 3, 0};
    int gap;
    int exp_gap;

    dig_slot_arbiter #(
        .N_AGENTS (4),
        .ACK_WIN  (2),
        .MAX_HOLD (31),
        .COOLDOWN (3)
    ) dut (
        .clk     (clk),
        .areset  (areset),
        .req     (req),
        .busy    (busy),
        .grant   (grant),
        .owner   (owner),
        .active  (active),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cool_wait();
`ifdef DIG_ARB_COOLDOWN_EN
        for (int c = 0; c < 3; c++) begin
            step();
            chk("cool_zero", grant, 0);
        end
`endif
    endtask

    initial begin
        areset = 1'b1;
        req    = '0;
        busy   = '0;
        #22;
        chk("rst_grant", grant, 0);
        chk("rst_owner", owner, 0);
        chk("rst_active", active, 0);
        chk("rst_timeout", timeout, 0);
        areset = 1'b0;
        step();

        // single requester
        req = 4'b0100;
        step();
        chk("t1_grant", grant, 4'b0100);
        chk("t1_owner", owner, 2);
        chk("t1_active", active, 1);
        busy = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t1_hold", grant, 4'b0100);
            chk("t1_no_to", timeout, 0);
        end
        busy = '0;
        req  = '0;
        step();
        chk("t1_rel", grant, 0);
        chk("t1_rel_to", timeout, 0);
        chk("t1_rel_act", active, 0);
        chk("t1_rel_own", owner, 2);

        // contention fairness from a fresh pointer
        #2 areset = 1'b1;
        #2 areset = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t2_grant", grant, 32'(1 << order[k]));
            chk("t2_owner", owner, 32'(order[k]));
            busy = 4'(1 << order[k]);
            step();
            step();
            step();
            chk("t2_busy", grant, 32'(1 << order[k]));
            busy = '0;
            if (k == 4) req = '0;
            step();
            chk("t2_gap", grant, 0);
            cool_wait();
        end

        // ack timeout; agent 2 next
        req = 4'b0010;
        step();
        chk("t3_grant", grant, 4'b0010);
        chk("t3_to0", timeout, 0);
        req = 4'b0110;
        step();
        chk("t3_wait", grant, 4'b0010);
        chk("t3_to1", timeout, 0);
        step();
        chk("t3_revoke", grant, 0);
        chk("t3_pulse", timeout, 1);
        chk("t3_act", active, 0);
        cool_wait();
        step();
        chk("t3_next", grant, 4'b0100);
        chk("t3_owner", owner, 2);
        chk("t3_to_once", timeout, 0);

        // hold overrun
        req  = '0;
        busy = 4'b0100;
        step();
        for (int i = 0; i < 30; i++) begin
            step();
            chk("t4_hold", grant, 4'b0100);
        end
        step();
        chk("t4_revoke", grant, 0);
        chk("t4_pulse", timeout, 1);
        step();
        chk("t4_pulse_end", timeout, 0);
        busy = '0;

        // release-to-grant gap
        req = 4'b0011;
        for (int n = 0; n < 10 && grant == 0; n++) step();
        chk("t5_first", grant, 4'b0001);
        busy = 4'b0001;
        step();
        busy = '0;
        step();
        chk("t5_rel", grant, 0);
        gap = 1;
`ifdef DIG_ARB_COOLDOWN_EN
        exp_gap = 4;
`else
        exp_gap = 1;
`endif
        for (int n = 0; n < 10 && grant == 0; n++) begin
            step();
            if (grant == 0) gap++;
        end
        chk("t5_gap", 32'(gap), 32'(exp_gap));
        chk("t5_second", grant, 4'b0010);
        req  = '0;
        busy = 4'b0010;
        step();
        busy = '0;
        step();
        chk("t5_rel2", grant, 0);

        // async reset mid-hold
        req = 4'b1000;
        for (int n = 0; n < 10 && grant == 0; n++) step();
        chk("t6_grant", grant, 4'b1000);
        busy = 4'b1000;
        step();
        step();
        chk("t6_hold", grant, 4'b1000);
        #3 areset = 1'b1;
        #1;
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_active", active, 0);
        #1;
        req    = 4'b1111;
        busy   = '0;
        areset = 1'b0;
        step();
        chk("t6_after", grant, 4'b0001);
        chk("t6_owner", owner, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dig_slot_arbiter.md
# dig_slot_arbiter

Round-robin arbiter that shares a single dig slot among N lemming walker agents, so only one agent may dig at any time. It sits between the per-agent walker state machines and the terrain model. It takes each agent's dig request and busy (digging) status, and returns a one-hot grant. It also bounds how long a grant may be held and reports overruns.

## Interface
- N_AGENTS, 4, number of requesting agents (2..16)
- ACK_WIN, 2, cycles a granted agent has to raise busy before the grant is revoked (1..7)
- MAX_HOLD, 31, maximum cycles a grant may stay in HOLD before forced revoke (1..255)
- COOLDOWN, 3, idle cycles after any release, used only with cooldown enabled (1..15)

- clk  in  1  clock, rising edge
- areset  in  1  reset, asynchronous, active-high
- req  in  N_AGENTS  per-agent dig request (agent on ground, dig asserted)
- busy  in  N_AGENTS  per-agent "currently in digging state"
- grant  out  N_AGENTS  one-hot dig permission, registered
- owner  out  $clog2(N_AGENTS)  index of current or last grantee, registered
- active  out  1  high while any grant is asserted
- timeout  out  1  one-cycle pulse on forced revoke (ACK_WIN or MAX_HOLD expiry)

## Operation
- States: IDLE, GRANTED, HOLD, COOL.
- IDLE:
  - If any req bit is set, select the first set bit scanning from rr_ptr+1 upward and wrapping modulo N_AGENTS.
  - Load owner, set grant[owner], go to GRANTED.
  - rr_ptr is updated to the winner.
- GRANTED:
  - If busy[owner] is set, go to HOLD and clear hold_cnt.
  - Otherwise increment ack_cnt. When ack_cnt reaches ACK_WIN, revoke the grant, pulse timeout, and release.
- HOLD:
  - hold_cnt increments every cycle.
  - If busy[owner] falls, release normally with no timeout.
  - If hold_cnt reaches MAX_HOLD while busy is still high, revoke, pulse timeout, and release.
- Release: grant goes to 0 and the FSM enters COOL (cooldown enabled) or IDLE (cooldown disabled).
- COOL: counts COOLDOWN cycles with grant at 0, then returns to IDLE. Requests arriving during COOL are not granted until the FSM is back in IDLE.
- req and busy bits of non-owners are ignored outside IDLE.
- req[owner] dropping during GRANTED or HOLD has no effect; only busy governs release.
- Simultaneous release and new request: the request is evaluated only in the next IDLE cycle. There is no back-to-back grant without passing through IDLE.
- Fairness: an agent that just held the grant has the lowest priority in the next arbitration.
- Counters saturate and never wrap. ack_cnt is 3 bits, hold_cnt is 8 bits, cool_cnt is 4 bits.

## Timing
- Reset values:
  - grant = 0, owner = 0, active = 0, timeout = 0.
  - rr_ptr = N_AGENTS-1, so agent 0 wins first.
  - FSM starts in IDLE with all counters 0.
- Grant latency: req sampled high in IDLE at edge k gives grant visible after edge k+1.
- busy is sampled one cycle after grant rises at the earliest.
- Normal release: busy falling at edge k clears grant after edge k+1.
- timeout is high for exactly one cycle, coincident with the first cycle grant is 0.
- An areset assertion mid-grant drops grant immediately (asynchronously) and returns the FSM to IDLE.

## Configuration
- DIG_ARB_COOLDOWN_EN defined: the COOL state is present, and every release is followed by COOLDOWN cycles with no grant.
- DIG_ARB_COOLDOWN_EN undefined:
  - The COOL state and cool_cnt are compiled out.
  - Release goes directly to IDLE.
  - Minimum gap between grants is 1 IDLE cycle.

## Structure
- Shared package dig_arb_pkg: the arb_state_t enum (IDLE, GRANTED, HOLD, COOL) and the counter width localparams.
- Sub-module rr_pick: combinational round-robin priority picker (req, rr_ptr -> winner index, any).
- The arbiter FSM, counters and output registers stay in the top module.

## Test plan
- Single requester:
  - req=4'b0100 with busy[2] rising 1 cycle after grant and held 5 cycles.
  - Required: grant=4'b0100 after one edge, released one edge after busy falls, owner=2, timeout never pulses.
- Contention fairness:
  - req=4'b1111 held constant; each grantee asserts busy for 3 cycles.
  - Required: grant order 0,1,2,3,0; no two grant bits ever high together.
- ACK timeout:
  - req[1]=1 and busy stays 0.
  - Required: grant revoked after ACK_WIN=2 cycles in GRANTED; timeout pulses exactly once; agent 2 wins the next arbitration if requesting.
- Hold overrun:
  - busy[owner] held high forever.
  - Required: forced revoke when hold_cnt reaches MAX_HOLD=31; one timeout pulse; grant 0.
- Cooldown (with DIG_ARB_COOLDOWN_EN):
  - req=4'b0011 continuous.
  - Required: exactly 3 zero-grant cycles plus 1 IDLE cycle between agent 0's release and agent 1's grant.
  - Without the macro, the gap is 1 cycle.
- Reset mid-HOLD:
  - Assert areset asynchronously while grant=4'b1000.
  - Required: grant and active drop immediately; after deassert with req=4'b1111, agent 0 is granted first.
